// File: rtl/down_timer_pkg.sv
// Shared definitions for the down-counting timer.
// Holds the FSM state encoding and the default counter width.
// No logic; imported by the timer top.
package down_timer_pkg;

  // Default width of count_out, load_value and the reload register
  localparam int TIMER_W = 3;

  // Timer FSM states, 2-bit encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : down_timer_pkg

// File: rtl/down_timer.sv
// Loadable down-counting timer with one-shot and auto-reload modes.
// Latency: all outputs registered; tc_pulse rises on the edge count reaches its terminal event.
// No backpressure: strobes are acted on the cycle they are seen, priority reset > load > stop > start > count.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = TIMER_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             periodic,
  input  logic             stop,
  output logic [WIDTH-1:0] count_out,
  output logic             tc_pulse,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;

  // Next-state and datapath: one prioritised decision per cycle
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;

    if (load) begin
      // Load wins over everything else and parks the timer in IDLE
      count_d  = load_value;
      reload_d = load_value;
      state_d  = IDLE;
    end else if (stop && (state_q == RUN)) begin
      // Abort: count is frozen where it was
      state_d = IDLE;
    end else if (start && (state_q != RUN)) begin
      mode_d  = periodic;
      count_d = reload_q;
      if (reload_q != '0) begin
        state_d = RUN;
      end else begin
        // A zero period expires immediately and behaves as one-shot
        tc_d    = 1'b1;
        state_d = DONE;
      end
    end else if ((state_q == RUN) && enable) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else if (count_q == WIDTH'(1)) begin
        tc_d = 1'b1;
        if (mode_q) begin
          // Auto-reload skips the zero value so the period is exactly reload_q
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = DONE;
        end
      end
    end
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
    end
  end

  assign count_out = count_q;
  assign tc_pulse  = tc_q;
  assign busy      = (state_q == RUN);

endmodule : down_timer

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed test-plan steps then random traffic.
// Outputs sampled 1 time unit after each rising edge.
// Compares against a behavioural model kept in integer form.
module tb_down_timer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_value = '0;
  logic       start = 1'b0;
  logic       periodic = 1'b0;
  logic       stop = 1'b0;
  logic [2:0] count_out;
  logic       tc_pulse;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a running flag plus integer count/period
  int m_count = 0;
  int m_period = 0;
  bit m_auto = 0;
  bit m_running = 0;
  bit m_tc = 0;
  int cycle_no = 0;

  down_timer #(.WIDTH(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .periodic   (periodic),
    .stop       (stop),
    .count_out  (count_out),
    .tc_pulse   (tc_pulse),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the timer's rules
  task automatic model_step();
    if (reset) begin
      m_count = 0; m_period = 0; m_auto = 0; m_running = 0; m_tc = 0;
    end else begin
      m_tc = 0;
      if (load) begin
        m_count = int'(load_value); m_period = int'(load_value); m_running = 0;
      end else if (stop && m_running) begin
        m_running = 0;
      end else if (start && !m_running) begin
        m_auto = periodic;
        m_count = m_period;
        if (m_period == 0) m_tc = 1;
        else m_running = 1;
      end else if (m_running && enable) begin
        m_count = m_count - 1;
        if (m_count == 0) begin
          m_tc = 1;
          if (m_auto) m_count = m_period;
          else m_running = 0;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare all outputs with the model
  task automatic cyc(input bit rst, input bit ld, input int lv, input bit st,
                     input bit per, input bit stp, input bit en);
    reset = rst; load = ld; load_value = 3'(lv); start = st;
    periodic = per; stop = stp; enable = en;
    @(posedge clock);
    model_step();
    cycle_no++;
    #1;
    chk("model_count", int'(count_out), m_count);
    chk("model_tc", int'(tc_pulse), int'(m_tc));
    chk("model_busy", int'(busy), int'(m_running));
  endtask

  initial begin
    int exp2[5];
    int exp4[7];
    int en4[7];
    int tc_cycles[$];
    int tc_total;
    bit saw_zero;
    bit saw_busy;

    // 1. Reset for two cycles, then idle with enable high
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("reset_count", int'(count_out), 0);
    chk("reset_tc", int'(tc_pulse), 0);
    chk("reset_busy", int'(busy), 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1);
    chk("idle_count", int'(count_out), 0);
    chk("idle_busy", int'(busy), 0);

    // 2. One-shot from 5
    cyc(0, 1, 5, 0, 0, 0, 1);
    chk("os_load", int'(count_out), 5);
    cyc(0, 0, 0, 1, 0, 0, 1);
    chk("os_start_count", int'(count_out), 5);
    chk("os_start_busy", int'(busy), 1);
    exp2 = '{4, 3, 2, 1, 0};
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("os_seq_count", int'(count_out), exp2[i]);
      chk("os_seq_tc", int'(tc_pulse), (i == 4) ? 1 : 0);
      chk("os_seq_busy", int'(busy), (i == 4) ? 0 : 1);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("os_done_count", int'(count_out), 0);
      chk("os_done_tc", int'(tc_pulse), 0);
    end

    // 3. Periodic with reload 3: pulses exactly 3 enabled cycles apart
    cyc(0, 1, 3, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1, 0, 1);
    chk("per_start_count", int'(count_out), 3);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("per_count", int'(count_out), 3 - ((i + 1) % 3));
      chk("per_busy", int'(busy), 1);
      if (tc_pulse) tc_cycles.push_back(cycle_no);
    end
    chk("per_tc_total", tc_cycles.size(), 3);
    if (tc_cycles.size() == 3) begin
      chk("per_tc_gap1", tc_cycles[1] - tc_cycles[0], 3);
      chk("per_tc_gap2", tc_cycles[2] - tc_cycles[1], 3);
    end

    // 4. Gated enable from 4
    cyc(0, 1, 4, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("gate_start", int'(count_out), 4);
    en4  = '{1, 0, 0, 1, 1, 0, 1};
    exp4 = '{3, 3, 3, 2, 1, 1, 0};
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 0, 0, 0, 0, en4[i] != 0);
      chk("gate_count", int'(count_out), exp4[i]);
      chk("gate_tc", int'(tc_pulse), (i == 6) ? 1 : 0);
    end

    // 5a. Load and start together: load wins
    cyc(0, 1, 6, 1, 0, 0, 1);
    chk("ld_st_count", int'(count_out), 6);
    chk("ld_st_busy", int'(busy), 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("ld_st_hold", int'(count_out), 6);
    // 5b. Stop and start together while running: stop wins, count held
    cyc(0, 0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("run_count", int'(count_out), 5);
    cyc(0, 0, 0, 1, 0, 1, 1);
    chk("stop_busy", int'(busy), 0);
    chk("stop_count", int'(count_out), 5);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("stop_hold", int'(count_out), 5);
    // 5c. Reset while running at count 2
    cyc(0, 1, 4, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("pre_rst_count", int'(count_out), 2);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("rst_run_count", int'(count_out), 0);
    chk("rst_run_tc", int'(tc_pulse), 0);
    chk("rst_run_busy", int'(busy), 0);

    // 6a. Zero period: immediate single pulse, never busy
    cyc(0, 1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1, 0, 1);
    chk("zero_tc", int'(tc_pulse), 1);
    chk("zero_busy", int'(busy), 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("zero_tc_fall", int'(tc_pulse), 0);
    chk("zero_busy2", int'(busy), 0);

    // 6b. Maximum period, periodic: pulse every 7 cycles, no zero shown
    cyc(0, 1, 7, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1, 0, 1);
    tc_total = 0;
    saw_zero = 0;
    for (int i = 0; i < 21; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      if (tc_pulse) tc_total++;
      if (count_out == 3'd0) saw_zero = 1;
    end
    chk("max_tc_total", tc_total, 3);
    chk("max_no_zero", int'(saw_zero), 0);
    chk("max_count_end", int'(count_out), 7);

    // Random traffic against the model
    saw_busy = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 64) == 0, ($urandom % 12) == 0, int'($urandom % 8),
          ($urandom % 6) == 0, $urandom % 2 == 1, ($urandom % 16) == 0,
          ($urandom % 4) != 0);
      if (busy) saw_busy = 1;
    end
    chk("rand_saw_busy", int'(saw_busy), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_down_timer

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable down-counting timer; complements the existing up-counter.
- Counts a programmed value down to zero on enabled cycles and emits a one-cycle terminal-count pulse.
- Supports one-shot and periodic (auto-reload) modes.
- Sits beside the up-counters in the timing/control path; drives event strobes to downstream control logic.

Parameters:
WIDTH, 3, bit width of count_out, load_value and the internal reload register

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  active-high count enable; a decrement occurs only on an enabled RUN cycle
load  input  1  one-cycle strobe: capture load_value into count and reload registers
load_value  input  WIDTH  value captured on load
start  input  1  one-cycle strobe: begin counting from current reload value
periodic  input  1  mode, sampled on start: 1 = auto-reload, 0 = one-shot
stop  input  1  one-cycle strobe: abort counting, hold count_out
count_out  output  WIDTH  current count, registered
tc_pulse  output  1  terminal-count pulse, registered, high exactly one cycle
busy  output  1  high while in RUN

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clock.
- Reset values: count_out=0, reload_reg=0, mode_reg=0, tc_pulse=0, busy=0, state=IDLE.
- Reset mid-operation aborts immediately; no tc_pulse is emitted.
- FSM states are IDLE, RUN and DONE.
- busy=1 only in RUN, registered with the state.
- Priority per edge: reset > load > stop > start > decrement.
- load (any state):
  - count_out<=load_value, reload_reg<=load_value, next state IDLE, tc_pulse<=0.
  - A simultaneous start or stop is ignored.
- stop in RUN: next state IDLE, count_out held, no tc_pulse. stop in IDLE/DONE: no effect.
- start in IDLE or DONE:
  - mode_reg<=periodic, count_out<=reload_reg.
  - If reload_reg!=0, next state RUN.
  - If reload_reg==0, tc_pulse<=1 next cycle and state DONE, regardless of periodic. Zero period is treated as one-shot.
- start in RUN: ignored, including a change of periodic.
- RUN, enable=0: count_out and state held; tc_pulse<=0.
- RUN, enable=1, count_out>1: count_out<=count_out-1.
- RUN, enable=1, count_out==1: tc_pulse<=1 on that edge.
  - One-shot: count_out<=0, next state DONE, busy falls on the same edge.
  - Periodic: count_out<=reload_reg, stay in RUN.
- Period: exactly reload_reg enabled cycles between tc_pulses. A reload of 1 gives tc_pulse on every enabled cycle.
- tc_pulse falls the following cycle unless another terminal event occurs. It is never high for two cycles, except in periodic mode with reload=1 and enable held high.
- No underflow: count_out never decrements below 0 and never wraps to 2^WIDTH-1.
- Arithmetic: unsigned, WIDTH bits. Maximum load is 2^WIDTH-1 (7 at default).
- DONE holds count_out=0 until load or start; from DONE, start restarts from reload_reg.

Decomposition:
- Shared package holds the state enum (IDLE/RUN/DONE, 2-bit encoding) and the default width constant TIMER_W=3.
- Single module; no sub-module is warranted.

Test Plan:
1. Assert reset 2 cycles, then release -> count_out=0, tc_pulse=0, busy=0, no change with enable=1 and no start.
2. load_value=5, load; then start with periodic=0, enable held 1 -> count_out 5,4,3,2,1,0; tc_pulse high only on the 0 cycle; busy 1→0 on same edge; stays 0 for 5 more cycles.
3. load_value=3, periodic=1, start, enable=1 for 9 cycles -> count_out 3,2,1,3,2,1,3,2,1; tc_pulse on 3 cycles spaced exactly 3 apart; busy stays 1.
4. load 4, start, enable pattern 1,0,0,1,1,0,1 -> count 4,3,3,3,2,1,1,0; tc_pulse only with the final decrement.
5. Priority cases:
   - load_value=6 with load and start in the same cycle -> count_out=6, state IDLE, busy=0.
   - stop and start together in RUN -> IDLE, count held.
   - reset during RUN at count 2 -> all outputs 0 next cycle, no tc_pulse.
6. load_value=0, start -> tc_pulse high one cycle, busy never asserts. load_value=7 with periodic=1 -> tc_pulse every 7 enabled cycles, count never shows 0.
